// File: rtl/clk_meter.sv
// clk_meter: measures period and high time of a slow asynchronous square wave
// in clk cycles, checks both against expected values within a tolerance, and
// reports lock and loss-of-signal.
module clk_meter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned EXP_PERIOD = 120,
  parameter int unsigned EXP_HIGH   = 60,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             err,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned      LCK_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   EXP_P_W  = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   EXP_H_W  = (CNT_W+1)'(EXP_HIGH);
  localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);
  localparam logic [LCK_W-1:0] LOCK_N_W = LCK_W'(LOCK_N);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic [CNT_W-1:0]   pcnt, hcnt, hlat;
  logic [LCK_W-1:0]   good_cnt;

  logic               rise, fall, pcnt_sat, hcnt_sat;
  logic signed [CNT_W:0] per_diff, hi_diff;
  logic [CNT_W:0]     per_abs, hi_abs;
  logic               meas_bad_c;
  logic [LCK_W-1:0]   good_nxt;

  // Edge detection, saturation flags and tolerance check of the current counts
  always_comb begin
    rise       = s2 & ~s3;
    fall       = ~s2 & s3;
    pcnt_sat   = (pcnt == CNT_MAX);
    hcnt_sat   = (hcnt == CNT_MAX);
    per_diff   = $signed({1'b0, pcnt}) - $signed(EXP_P_W);
    hi_diff    = $signed({1'b0, hlat}) - $signed(EXP_H_W);
    per_abs    = per_diff[CNT_W] ? $unsigned(-per_diff) : $unsigned(per_diff);
    hi_abs     = hi_diff[CNT_W]  ? $unsigned(-hi_diff)  : $unsigned(hi_diff);
    meas_bad_c = (per_abs > TOL_W) || (hi_abs > TOL_W);
    good_nxt   = good_cnt;
    if (meas_bad_c) begin
      good_nxt = '0;
    end else if (good_cnt != LOCK_N_W) begin
      good_nxt = good_cnt + LCK_W'(1);
    end
  end

  // Synchronizer, saturating period/high counters and high-time latch
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      pcnt <= '0;
      hcnt <= '0;
      hlat <= '0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
      if (rise) begin
        pcnt <= CNT_W'(1);
      end else if (!pcnt_sat) begin
        pcnt <= pcnt + CNT_W'(1);
      end
      if (rise) begin
        hcnt <= CNT_W'(1);
      end else if (s2 && !hcnt_sat) begin
        hcnt <= hcnt + CNT_W'(1);
      end
      if (fall) begin
        hlat <= hcnt;
      end
    end
  end

  // Measurement FSM with registered results, lock tracking and timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      good_cnt   <= '0;
    end else begin
      meas_valid <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= ARMED;
          end
        end
        ARMED, RUN: begin
          if (rise) begin
            // a rise coinciding with saturation still yields a measurement
            state      <= RUN;
            period     <= pcnt;
            high_time  <= hlat;
            meas_valid <= 1'b1;
            err        <= meas_bad_c;
            good_cnt   <= good_nxt;
            locked     <= (good_nxt == LOCK_N_W);
          end else if (pcnt_sat) begin
            state    <= IDLE;
            timeout  <= 1'b1;
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
